cook_timer_ctrl: RTL

Sequencing controller for the microwave's MM:SS countdown. Captures keypad digits into a 4-digit BCD entry buffer, presets the counter chain, and gates the chain's count enable from a 1 Hz tick. Handles start, stop, pause and door interlock, detects 00:00, and drives the magnetron and the end-of-cook beep. Sits between the keypad/door inputs and the cascaded mod-10/mod-6 down-counters.

---
 rtl/cook_pkg.sv | 27 ++
 rtl/cook_timer_ctrl_if.sv | 32 +++
 rtl/bcd_entry_buf.sv | 37 +++
 rtl/cook_timer_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cook_pkg.sv
// Shared types and constants for the microwave cook timer controller.
package cook_pkg;

  localparam int unsigned BCD_W        = 4;
  localparam int unsigned MMSS_W       = 4 * BCD_W;
  localparam logic [3:0]  MAX_SEC_TENS = 4'd5;
  localparam logic [3:0]  MAX_BCD      = 4'd9;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_units;
    bcd_t sec_tens;
    bcd_t sec_units;
  } mmss_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_LOAD,
    ST_RUN,
    ST_PAUSED,
    ST_DONE
  } cook_state_e;

endpackage

// File: rtl/cook_timer_ctrl_if.sv
// Keypad/door/counter-chain signal bundle for the cook timer controller.
interface cook_timer_ctrl_if;
  import cook_pkg::*;

  logic  tick;
  logic  key_valid;
  bcd_t  key_digit;
  logic  start;
  logic  stop;
  logic  door_closed;
  mmss_t digits;

  mmss_t preset;
  logic  cnt_load_n;
  logic  cnt_clear_n;
  logic  count_en;
  logic  magnetron_on;
  logic  beep;
  logic  done;
  logic  entry_err;

  modport master (
    output tick, key_valid, key_digit, start, stop, door_closed, digits,
    input  preset, cnt_load_n, cnt_clear_n, count_en, magnetron_on, beep, done, entry_err
  );

  modport slave (
    input  tick, key_valid, key_digit, start, stop, door_closed, digits,
    output preset, cnt_load_n, cnt_clear_n, count_en, magnetron_on, beep, done, entry_err
  );

endinterface

// File: rtl/bcd_entry_buf.sv
// Four-digit BCD keypad entry shift register with digit and MM:SS validity checks.
module bcd_entry_buf
  import cook_pkg::*;
#(
  parameter logic [7:0] QUICK_SECS = 8'h30
) (
  input  logic  clock,
  input  logic  clear,
  input  logic  flush,
  input  logic  quick_load,
  input  logic  shift,
  input  bcd_t  key_digit,
  output mmss_t preset,
  output logic  digit_ok_c,
  output logic  zero_c,
  output logic  sec_ok_c
);

  logic [MMSS_W-1:0] shifted;

  assign shifted    = {preset[MMSS_W-BCD_W-1:0], key_digit};
  assign digit_ok_c = (key_digit <= MAX_BCD);
  assign zero_c     = (preset == mmss_t'('0));
  assign sec_ok_c   = (preset.sec_tens <= MAX_SEC_TENS);

  // Flush wins over quick-start preset, which wins over a new digit.
  always_ff @(posedge clock) begin
    if (clear || flush) begin
      preset <= mmss_t'('0);
    end else if (quick_load) begin
      preset <= mmss_t'({8'h00, QUICK_SECS});
    end else if (shift) begin
      preset <= mmss_t'(shifted);
    end
  end

endmodule

// File: rtl/cook_timer_ctrl.sv
// Cook timer sequencing FSM: entry, load, countdown gating, pause and end-of-cook.
// Define COOK_BEEP_EN to hold the end-of-cook beep for BEEP_TICKS seconds.
module cook_timer_ctrl
  import cook_pkg::*;
#(
  parameter logic [7:0] QUICK_SECS = 8'h30
`ifdef COOK_BEEP_EN
  , parameter int unsigned BEEP_TICKS = 3
`endif
) (
  input  logic              clock,
  input  logic              clear,
  cook_timer_ctrl_if.slave  bus
);

  cook_state_e state_q, state_d;

  logic key_shift_c, quick_load_c, flush_c;
  logic digit_ok_c, zero_c, sec_ok_c;
  logic digits_zero_c, door_open_c, key_ok_c;

  logic cnt_load_n_d, cnt_clear_n_d, count_en_d, magnetron_on_d, done_d, entry_err_d;

`ifdef COOK_BEEP_EN
  localparam int unsigned BEEP_CNT_W = 4;
  logic [BEEP_CNT_W-1:0] beep_cnt_q, beep_cnt_d;
  logic                  beep_d;
`endif

  bcd_entry_buf #(.QUICK_SECS(QUICK_SECS)) u_entry (
    .clock      (clock),
    .clear      (clear),
    .flush      (flush_c),
    .quick_load (quick_load_c),
    .shift      (key_shift_c),
    .key_digit  (bus.key_digit),
    .preset     (bus.preset),
    .digit_ok_c (digit_ok_c),
    .zero_c     (zero_c),
    .sec_ok_c   (sec_ok_c)
  );

  assign digits_zero_c = (bus.digits == mmss_t'('0));
  assign door_open_c   = !bus.door_closed;
  assign key_ok_c      = bus.key_valid && digit_ok_c;

  // Next state and next output values; priority door > stop > start > key > tick.
  always_comb begin
    state_d       = state_q;
    key_shift_c   = 1'b0;
    quick_load_c  = 1'b0;
    flush_c       = 1'b0;
    cnt_clear_n_d = 1'b1;
    count_en_d    = 1'b0;
    done_d        = 1'b0;
    entry_err_d   = 1'b0;
`ifdef COOK_BEEP_EN
    beep_cnt_d    = beep_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start && bus.door_closed) begin
          quick_load_c = 1'b1;
          state_d      = ST_LOAD;
        end else if (key_ok_c) begin
          key_shift_c = 1'b1;
          state_d     = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (bus.stop) begin
          flush_c       = 1'b1;
          cnt_clear_n_d = 1'b0;
          state_d       = ST_IDLE;
        end else if (bus.start) begin
          if (bus.door_closed && !zero_c && sec_ok_c) begin
            state_d = ST_LOAD;
          end else begin
            entry_err_d = 1'b1;
          end
        end else if (key_ok_c) begin
          key_shift_c = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (door_open_c || bus.stop) begin
          state_d = ST_PAUSED;
        end else if (digits_zero_c) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
`ifdef COOK_BEEP_EN
          beep_cnt_d = '0;
`endif
        end else if (bus.tick) begin
          count_en_d = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (bus.stop) begin
          flush_c       = 1'b1;
          cnt_clear_n_d = 1'b0;
          state_d       = ST_IDLE;
        end else if (bus.start && bus.door_closed) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
`ifdef COOK_BEEP_EN
        if (door_open_c || bus.stop) begin
          flush_c = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.tick) begin
          if (beep_cnt_q == BEEP_CNT_W'(BEEP_TICKS - 1)) begin
            flush_c = 1'b1;
            state_d = ST_IDLE;
          end else begin
            beep_cnt_d = beep_cnt_q + BEEP_CNT_W'(1);
          end
        end
`else
        flush_c = 1'b1;
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cnt_load_n_d   = (state_d != ST_LOAD);
    magnetron_on_d = (state_d == ST_RUN);
`ifdef COOK_BEEP_EN
    beep_d         = (state_d == ST_DONE);
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q          <= ST_IDLE;
      bus.cnt_load_n   <= 1'b1;
      bus.cnt_clear_n  <= 1'b0;
      bus.count_en     <= 1'b0;
      bus.magnetron_on <= 1'b0;
      bus.done         <= 1'b0;
      bus.entry_err    <= 1'b0;
    end else begin
      state_q          <= state_d;
      bus.cnt_load_n   <= cnt_load_n_d;
      bus.cnt_clear_n  <= cnt_clear_n_d;
      bus.count_en     <= count_en_d;
      bus.magnetron_on <= magnetron_on_d;
      bus.done         <= done_d;
      bus.entry_err    <= entry_err_d;
    end
  end

`ifdef COOK_BEEP_EN
  always_ff @(posedge clock) begin
    if (clear) begin
      beep_cnt_q <= '0;
      bus.beep   <= 1'b0;
    end else begin
      beep_cnt_q <= beep_cnt_d;
      bus.beep   <= beep_d;
    end
  end
`else
  always_ff @(posedge clock) begin
    bus.beep <= 1'b0;
  end
`endif

endmodule
